xgmii_tx_frame_arbiter: RTL and testbench
=========================================

// Module: xgmii_tx_frame_arbiter
// PURPOSE
//  Frame-atomic round-robin arbiter sharing the single 72-bit XGMII TX FIFO write port between NUM_REQ frame sources.
//  Example sources: PCIe TLP capture and local responders.
//  Sits between the per-source FWFT FIFOs and the TX FIFO drained by the XGMII TX engine.
//  Never interleaves beats of two frames. Polices frame framing and length.
// PARAMETERS
//  NUM_REQ    2   number of requesters (2..4); bit i of vector ports = requester i
//  MAX_BEATS  64  max beats per frame incl. start beat; exceeding it aborts the frame
// PORTS
//  xgmii_clk    in   1           sole clock; everything below is synchronous to it
//  sys_rst      in   1           synchronous active-high reset
//  req_dout     in   72*NUM_REQ  requester FWFT FIFO head words, i at [72*i+:72]
//  req_empty    in   NUM_REQ     requester FIFO empty (head word invalid when 1)
//  req_rd_en    out  NUM_REQ     pop head word of requester i (combinational)
//  tx_din       out  72          TX FIFO write data (registered)
//  tx_wr_en     out  1           TX FIFO write strobe (registered)
//  tx_afull     in   1           TX FIFO almost full, asserted with >=2 free entries
//  arb_enable   in   1           1 = new grants allowed
//  grant        out  NUM_REQ     one-hot current owner, 0 when idle
//  frame_cnt    out  32          frames completed normally, wraps
//  drop_cnt     out  16          framing errors + aborted frames, saturates at FFFF
// BEHAVIOUR
//  Word format: [63:0] data, [64] start, [65] last, [66] lo-dword en, [67] hi-dword en, [68] IFG, [71:69] passed through.
//  Reset: all outputs 0. Internal state: st=IDLE, rr_ptr=0, beat_cnt=0.
//   Reset mid-frame drops any registered write; no tx_wr_en in the cycle after reset.
//  States:
//   IDLE:
//    - If arb_enable, search for a non-empty requester, starting at rr_ptr and wrapping modulo NUM_REQ.
//    - On finding one: set grant and go to SOF. Grant decision takes 1 cycle.
//   SOF (first beat), when ~req_empty[own] & ~tx_afull:
//    - Head has [64]=1: pop it, write it, beat_cnt=1.
//      If [65] is also 1 (single-beat frame): DONE; else BODY.
//    - Head has [64]=0: pop and discard, drop_cnt++ once per run of junk, stay in SOF.
//   BODY, when ~req_empty[own] & ~tx_afull:
//    - Pop the head, write it, beat_cnt++.
//    - Head has [65]=1: DONE.
//    - Head has [64]=1 (start inside a frame): do NOT pop.
//      Write terminator {[65]=1, data 0, en 0}, drop_cnt++, go to DONE.
//      The new frame is re-arbitrated normally.
//    - beat_cnt reaches MAX_BEATS without [65]:
//      Write the terminator in place of a pop, drop_cnt++, go to DISCARD.
//   DISCARD:
//    - Pop own words without writing until a popped word has [65]=1 -> DONE.
//    - A head with [64]=1 is left unpopped -> DONE.
//   DONE (1 cycle):
//    - frame_cnt++ only for normal [65] completion.
//    - rr_ptr = owner+1 mod NUM_REQ; grant=0; go to IDLE.
//  Stalls: empty or afull in SOF/BODY/DISCARD -> no pop, no write, state held indefinitely.
//   The tx_afull margin covers the one registered in-flight write.
//  Writes: tx_wr_en/tx_din registered 1 cycle after pop. Data bits are unmodified.
//  req_rd_en: at most one bit high, only for the owner, only when that owner is non-empty.
//  arb_enable deasserted mid-frame: the current frame completes; no new grant is made.
//  Fairness: after each frame the owner gets lowest priority.
//   Back-to-back frames cost 2 idle write cycles (DONE+IDLE).
//  frame_cnt wraps at 2^32. drop_cnt saturates.
// TESTING
//  1 Req0 queues 3-beat frame (S,-,L): 3 writes, identical words, 1 cycle after each pop; frame_cnt=1, grant returns to 0.
//  2 Both reqs hold 2 frames each, rr_ptr=0: write order r0,r1,r0,r1, no interleaved beats; frame_cnt=4.
//  3 tx_afull pulsed 5 cycles mid-frame: no pop/write while high; the frame resumes intact with no loss or duplicate.
//  4 Req1 frame of 70 beats, MAX_BEATS=64: 63 data beats + terminator word 0x2_0000_0000_0000_0000, remaining 7 discarded, drop_cnt=1.
//  5 Req0 head junk word [64]=0, then a valid 2-beat frame: junk popped but not written, drop_cnt=1, frame passed, frame_cnt=1.
//  6 sys_rst asserted in BODY: the next cycle has all outputs 0; after release, a fresh frame from req0 is granted first.

Source files
------------

// File: rtl/xgmii_tx_frame_arbiter_if.sv
// XGMII TX frame arbiter bus bundle.
// Requester FIFO heads/pops, TX FIFO write port, control, counters.
interface xgmii_tx_frame_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [72*NUM_REQ-1:0] req_dout;
  logic [NUM_REQ-1:0]    req_empty;
  logic [NUM_REQ-1:0]    req_rd_en;
  logic [71:0]           tx_din;
  logic                  tx_wr_en;
  logic                  tx_afull;
  logic                  arb_enable;
  logic [NUM_REQ-1:0]    grant;
  logic [31:0]           frame_cnt;
  logic [15:0]           drop_cnt;

  modport master (
    input  req_dout, req_empty, tx_afull, arb_enable,
    output req_rd_en, tx_din, tx_wr_en, grant,
    output frame_cnt, drop_cnt
  );

  modport slave (
    output req_dout, req_empty, tx_afull, arb_enable,
    input  req_rd_en, tx_din, tx_wr_en, grant,
    input  frame_cnt, drop_cnt
  );
endinterface

// File: rtl/xgmii_tx_frame_arbiter.sv
// Frame-atomic round-robin arbiter onto the 72-bit XGMII TX FIFO.
// Ports: xgmii_clk, sys_rst (sync, active high), bus (master):
//   req_dout/req_empty/req_rd_en per-source FWFT heads and pops,
//   tx_din/tx_wr_en registered TX write, tx_afull stall,
//   arb_enable, grant (one-hot owner), frame_cnt, drop_cnt.
module xgmii_tx_frame_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BEATS = 64
) (
  input logic                      xgmii_clk,
  input logic                      sys_rst,
  xgmii_tx_frame_arbiter_if.master bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BEATS + 1);
  // Forced end-of-frame word: only the last flag set.
  localparam logic [71:0] TERM = 72'h2_0000_0000_0000_0000;

  typedef enum logic [2:0] {
    IDLE, SOF, BODY, DISCARD, DONE
  } st_t;

  st_t                st, st_n;
  logic [IW-1:0]      own, own_n;
  logic [IW-1:0]      rr_ptr, rr_n;
  logic [BW-1:0]      beat_cnt, beat_n;
  logic               junk, junk_n;
  logic               ok, ok_n;
  logic [NUM_REQ-1:0] grant_n;
  logic               wr_n;
  logic [71:0]        din_n;
  logic               drop_inc;
  logic               pop;
  logic [71:0]        head;
  logic               own_empty;
  logic               own_rdy;
  logic               found;
  logic [IW-1:0]      pick;

  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % NUM_REQ);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(
    input logic [IW-1:0] i
  );
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  always_comb begin
    head = '0;
    own_empty = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == own) begin
        head = bus.req_dout[72*i +: 72];
        own_empty = bus.req_empty[i];
      end
    end
  end

  assign own_rdy = ~own_empty & ~bus.tx_afull;

  // First non-empty source at or after rr_ptr.
  always_comb begin
    found = 1'b0;
    pick = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found &&
          !bus.req_empty[wrap(int'(rr_ptr) + k)]) begin
        found = 1'b1;
        pick = wrap(int'(rr_ptr) + k);
      end
    end
  end

  always_comb begin
    st_n = st;
    own_n = own;
    rr_n = rr_ptr;
    beat_n = beat_cnt;
    junk_n = junk;
    ok_n = ok;
    grant_n = bus.grant;
    wr_n = 1'b0;
    din_n = head;
    drop_inc = 1'b0;
    pop = 1'b0;
    unique case (st)
      IDLE: begin
        if (bus.arb_enable && found) begin
          own_n = pick;
          grant_n = onehot(pick);
          beat_n = '0;
          junk_n = 1'b0;
          ok_n = 1'b0;
          st_n = SOF;
        end
      end
      SOF: begin
        if (own_rdy) begin
          pop = 1'b1;
          if (head[64]) begin
            wr_n = 1'b1;
            beat_n = BW'(1);
            junk_n = 1'b0;
            ok_n = head[65];
            st_n = head[65] ? DONE : BODY;
          end else begin
            // One drop per contiguous run of junk.
            drop_inc = ~junk;
            junk_n = 1'b1;
          end
        end
      end
      BODY: begin
        if (own_rdy) begin
          if (head[64]) begin
            // Leave the new start for re-arbitration.
            wr_n = 1'b1;
            din_n = TERM;
            drop_inc = 1'b1;
            st_n = DONE;
          end else if (head[65]) begin
            pop = 1'b1;
            wr_n = 1'b1;
            beat_n = beat_cnt + BW'(1);
            ok_n = 1'b1;
            st_n = DONE;
          end else if (beat_cnt == BW'(MAX_BEATS - 1)) begin
            // Terminator takes the final beat slot.
            wr_n = 1'b1;
            din_n = TERM;
            drop_inc = 1'b1;
            st_n = DISCARD;
          end else begin
            pop = 1'b1;
            wr_n = 1'b1;
            beat_n = beat_cnt + BW'(1);
          end
        end
      end
      DISCARD: begin
        if (own_rdy) begin
          if (head[64]) begin
            st_n = DONE;
          end else begin
            pop = 1'b1;
            if (head[65]) st_n = DONE;
          end
        end
      end
      DONE: begin
        rr_n = wrap(int'(own) + 1);
        grant_n = '0;
        st_n = IDLE;
      end
      default: st_n = IDLE;
    endcase
    bus.req_rd_en = pop ? onehot(own) : '0;
  end

  always_ff @(posedge xgmii_clk) begin
    if (sys_rst) begin
      st <= IDLE;
      own <= '0;
      rr_ptr <= '0;
      beat_cnt <= '0;
      junk <= 1'b0;
      ok <= 1'b0;
      bus.grant <= '0;
      bus.tx_wr_en <= 1'b0;
      bus.tx_din <= '0;
      bus.frame_cnt <= '0;
      bus.drop_cnt <= '0;
    end else begin
      st <= st_n;
      own <= own_n;
      rr_ptr <= rr_n;
      beat_cnt <= beat_n;
      junk <= junk_n;
      ok <= ok_n;
      bus.grant <= grant_n;
      bus.tx_wr_en <= wr_n;
      if (wr_n) bus.tx_din <= din_n;
      if (st == DONE && ok)
        bus.frame_cnt <= bus.frame_cnt + 32'd1;
      if (drop_inc && bus.drop_cnt != 16'hFFFF)
        bus.drop_cnt <= bus.drop_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_xgmii_tx_frame_arbiter.sv
// Testbench for xgmii_tx_frame_arbiter.
// Queue-based source model, frame-level reference, per-cycle compare.
module tb_xgmii_tx_frame_arbiter;
  localparam int NR = 2;
  localparam int MB = 64;
  localparam logic [71:0] TERM = 72'h2_0000_0000_0000_0000;

  logic xgmii_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 xgmii_clk = ~xgmii_clk;

  xgmii_tx_frame_arbiter_if #(.NUM_REQ(NR)) sif ();

  xgmii_tx_frame_arbiter #(
    .NUM_REQ(NR),
    .MAX_BEATS(MB)
  ) dut (
    .xgmii_clk(xgmii_clk),
    .sys_rst(sys_rst),
    .bus(sif.master)
  );

  int n_tests = 0;
  int n_fail = 0;
  logic [71:0] sq [NR][$];
  logic [71:0] mq [NR][$];
  logic [71:0] expq [$];
  int exp_frames, exp_drops;
  bit chk_en = 0, gap_en = 0, afull_rnd = 0, afull_force = 0;
  bit arb_on = 0, arb_rnd = 0;
  int cyc = 0, wr_total = 0, pops_total = 0;
  logic prev_afull = 1'b0;
  int pop_cyc [$];
  int wr_cyc [$];

  task automatic check(input string nm, input logic [71:0] act,
                       input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic int sq_total();
    int t = 0;
    for (int i = 0; i < NR; i++) t += sq[i].size();
    return t;
  endfunction

  // Source FIFOs and TX FIFO status.
  initial begin
    sif.req_dout = '0;
    sif.req_empty = '1;
    sif.tx_afull = 1'b0;
    sif.arb_enable = 1'b0;
    forever begin
      @(posedge xgmii_clk);
      for (int i = 0; i < NR; i++)
        if (sif.req_rd_en[i] && sq[i].size() > 0)
          void'(sq[i].pop_front());
      #1;
      begin
        bit gap;
        gap = gap_en && ($urandom_range(0, 3) == 0);
        for (int i = 0; i < NR; i++) begin
          if (sq[i].size() > 0) begin
            sif.req_dout[72*i +: 72] = sq[i][0];
            sif.req_empty[i] = gap;
          end else begin
            sif.req_dout[72*i +: 72] =
              {8'($urandom), $urandom, $urandom};
            sif.req_empty[i] = 1'b1;
          end
        end
        sif.tx_afull = afull_force ||
                       (afull_rnd && $urandom_range(0, 4) == 0);
        sif.arb_enable = arb_on &&
                         !(arb_rnd && $urandom_range(0, 4) == 0);
      end
    end
  end

  // Per-cycle compare against the reference stream.
  always @(negedge xgmii_clk) begin
    cyc++;
    if (sif.tx_wr_en) begin
      wr_total++;
      wr_cyc.push_back(cyc);
    end
    if (sif.req_rd_en != '0) begin
      pops_total++;
      pop_cyc.push_back(cyc);
    end
    if (chk_en) begin
      if (sif.tx_wr_en) begin
        if (expq.size() == 0)
          check("unexpected_write", sif.tx_din, 72'hx);
        else
          check("tx_din", sif.tx_din, expq.pop_front());
        check("write_after_afull", 72'(prev_afull), 0);
      end
      if (sif.req_rd_en != '0) begin
        check("rd_en_while_afull", 72'(sif.tx_afull), 0);
        check("rd_en_onehot", 72'($onehot(sif.req_rd_en)), 1);
        check("rd_en_empty",
              72'(|(sif.req_rd_en & sif.req_empty)), 0);
        check("rd_en_not_owner",
              72'(|(sif.req_rd_en & ~sif.grant)), 0);
      end
      check("grant_onehot0", 72'($onehot0(sif.grant)), 1);
    end
    prev_afull = sif.tx_afull;
  end

  function automatic logic [71:0] rw(input bit s, input bit l);
    logic [71:0] r;
    r = {8'($urandom), $urandom, $urandom};
    r[64] = s;
    r[65] = l;
    return r;
  endfunction

  task automatic push_w(input int s, input logic [71:0] v);
    sq[s].push_back(v);
    mq[s].push_back(v);
  endtask

  task automatic add_frame(input int s, input int len);
    for (int b = 0; b < len; b++)
      push_w(s, rw(b == 0, b == len - 1));
  endtask

  task automatic add_partial(input int s, input int len);
    for (int b = 0; b < len; b++) push_w(s, rw(b == 0, 1'b0));
  endtask

  task automatic add_junk(input int s, input int n);
    for (int b = 0; b < n; b++) push_w(s, rw(1'b0, 1'($urandom)));
  endtask

  // Reference: one whole frame from source o, per framing rules.
  task automatic serve(input int o);
    logic [71:0] h;
    int beats;
    bit junk;
    junk = 0;
    while (mq[o].size() > 0 && !mq[o][0][64]) begin
      void'(mq[o].pop_front());
      if (!junk) exp_drops++;
      junk = 1;
    end
    if (mq[o].size() == 0) return;
    h = mq[o].pop_front();
    expq.push_back(h);
    beats = 1;
    if (h[65]) begin
      exp_frames++;
      return;
    end
    while (mq[o].size() > 0) begin
      h = mq[o][0];
      if (h[64]) begin
        expq.push_back(TERM);
        exp_drops++;
        return;
      end
      if (h[65]) begin
        void'(mq[o].pop_front());
        expq.push_back(h);
        exp_frames++;
        return;
      end
      if (beats == MB - 1) begin
        expq.push_back(TERM);
        exp_drops++;
        while (mq[o].size() > 0 && !mq[o][0][64]) begin
          h = mq[o].pop_front();
          if (h[65]) break;
        end
        return;
      end
      void'(mq[o].pop_front());
      expq.push_back(h);
      beats++;
    end
  endtask

  task automatic model_build();
    int rr, o, tot;
    rr = 0;
    expq.delete();
    exp_frames = 0;
    exp_drops = 0;
    forever begin
      tot = 0;
      for (int i = 0; i < NR; i++) tot += mq[i].size();
      if (tot == 0) break;
      o = -1;
      for (int k = 0; k < NR; k++)
        if (o < 0 && mq[(rr + k) % NR].size() > 0) o = (rr + k) % NR;
      serve(o);
      rr = (o + 1) % NR;
    end
  endtask

  task automatic nclk();
    @(negedge xgmii_clk);
    #1;
  endtask

  task automatic do_reset();
    nclk();
    arb_on = 0;
    sys_rst = 1'b1;
    for (int i = 0; i < NR; i++) begin
      sq[i].delete();
      mq[i].delete();
    end
    expq.delete();
    repeat (2) nclk();
    sys_rst = 1'b0;
  endtask

  task automatic run_until_idle(input int budget);
    int n, settle;
    n = 0;
    settle = 0;
    while (settle < 4 && n < budget) begin
      nclk();
      n++;
      if (sq_total() == 0 && sif.grant == '0) settle++;
      else settle = 0;
    end
    check("phase_timeout", 72'(n >= budget), 0);
    check("exp_drained", 72'(expq.size()), 0);
    check("frame_cnt_model", sif.frame_cnt, 72'(exp_frames));
    check("drop_cnt_model", sif.drop_cnt, 72'(exp_drops));
  endtask

  task automatic wait_writes(input int n);
    int w0, k;
    w0 = wr_total;
    k = 0;
    while (wr_total - w0 < n && k < 300) begin
      nclk();
      k++;
    end
    check("wait_writes_timeout", 72'(k >= 300), 0);
  endtask

  initial begin
    logic [71:0] w0s;
    int p0, w1, nf;

    do_reset();
    check("rst_tx_wr_en", 72'(sif.tx_wr_en), 0);
    check("rst_tx_din", sif.tx_din, 0);
    check("rst_grant", 72'(sif.grant), 0);
    check("rst_frame_cnt", sif.frame_cnt, 0);
    check("rst_drop_cnt", sif.drop_cnt, 0);
    check("rst_rd_en", 72'(sif.req_rd_en), 0);
    chk_en = 1;

    // No grant while arbitration is disabled.
    add_frame(0, 3);
    p0 = pops_total;
    repeat (6) nclk();
    check("disabled_grant", 72'(sif.grant), 0);
    check("disabled_pops", 72'(pops_total - p0), 0);

    // Single 3-beat frame with write 1 cycle after each pop.
    model_build();
    check("model_t1_len", 72'(expq.size()), 3);
    pop_cyc.delete();
    wr_cyc.delete();
    arb_on = 1;
    run_until_idle(500);
    check("t1_frame_cnt", sif.frame_cnt, 1);
    check("t1_grant_idle", 72'(sif.grant), 0);
    check("t1_pops", 72'(pop_cyc.size()), 3);
    check("t1_writes", 72'(wr_cyc.size()), 3);
    for (int k = 0; k < 3 && k < pop_cyc.size() &&
         k < wr_cyc.size(); k++)
      check("t1_wr_latency", 72'(wr_cyc[k] - pop_cyc[k]), 1);

    // Round robin, two frames per source.
    do_reset();
    add_frame(0, 2);
    add_frame(0, 3);
    add_frame(1, 4);
    add_frame(1, 1);
    w0s = sq[1][0];
    model_build();
    check("model_t2_rr", expq[2], w0s);
    arb_on = 1;
    run_until_idle(500);
    check("t2_frame_cnt", sif.frame_cnt, 4);

    // tx_afull held 5 cycles mid-frame.
    do_reset();
    add_frame(0, 12);
    model_build();
    arb_on = 1;
    wait_writes(4);
    p0 = pops_total;
    afull_force = 1;
    nclk();
    w1 = wr_total;
    repeat (4) nclk();
    afull_force = 0;
    check("t3_pops_in_afull", 72'(pops_total - p0), 0);
    nclk();
    check("t3_writes_in_afull", 72'(wr_total - w1), 0);
    run_until_idle(500);
    check("t3_frame_cnt", sif.frame_cnt, 1);

    // Oversized frame from req1.
    do_reset();
    add_frame(1, 70);
    model_build();
    check("model_t4_len", 72'(expq.size()), 64);
    check("model_t4_term", expq[63], TERM);
    arb_on = 1;
    run_until_idle(1000);
    check("t4_drop_cnt", sif.drop_cnt, 1);
    check("t4_frame_cnt", sif.frame_cnt, 0);

    // Junk run ahead of a valid frame counts once.
    do_reset();
    add_junk(0, 2);
    add_frame(0, 2);
    model_build();
    check("model_t5_drops", 72'(exp_drops), 1);
    arb_on = 1;
    run_until_idle(500);
    check("t5_drop_cnt", sif.drop_cnt, 1);
    check("t5_frame_cnt", sif.frame_cnt, 1);

    // Reset in the middle of a frame.
    do_reset();
    chk_en = 0;
    add_frame(0, 10);
    arb_on = 1;
    wait_writes(3);
    sys_rst = 1'b1;
    arb_on = 0;
    nclk();
    check("t6_wr_en", 72'(sif.tx_wr_en), 0);
    check("t6_din", sif.tx_din, 0);
    check("t6_grant", 72'(sif.grant), 0);
    check("t6_frame_cnt", sif.frame_cnt, 0);
    check("t6_drop_cnt", sif.drop_cnt, 0);
    for (int i = 0; i < NR; i++) begin
      sq[i].delete();
      mq[i].delete();
    end
    expq.delete();
    sys_rst = 1'b0;
    nclk();
    check("t6_no_wr_after", 72'(sif.tx_wr_en), 0);
    add_frame(1, 3);
    add_frame(0, 2);
    w0s = sq[0][0];
    model_build();
    check("model_t6_first", expq[0], w0s);
    chk_en = 1;
    arb_on = 1;
    run_until_idle(500);
    check("t6_frame_cnt_after", sif.frame_cnt, 2);

    // Randomized traffic with gaps, stalls and framing faults.
    for (int ph = 0; ph < 3; ph++) begin
      do_reset();
      for (int s = 0; s < NR; s++) begin
        nf = $urandom_range(5, 9);
        for (int f = 0; f < nf; f++) begin
          case ($urandom_range(0, 9))
            0, 1, 2, 3: add_frame(s, $urandom_range(1, 6));
            4: begin
              add_junk(s, $urandom_range(1, 3));
              add_frame(s, $urandom_range(1, 4));
            end
            5: begin
              add_partial(s, $urandom_range(1, 4));
              add_frame(s, $urandom_range(1, 4));
            end
            6: add_frame(s, $urandom_range(MB - 1, MB + 1));
            7: add_frame(s, MB + $urandom_range(2, 8));
            default: add_frame(s, 1);
          endcase
        end
        add_frame(s, $urandom_range(1, 3));
      end
      model_build();
      gap_en = 1;
      afull_rnd = 1;
      arb_rnd = 1;
      arb_on = 1;
      run_until_idle(20000);
      gap_en = 0;
      afull_rnd = 0;
      arb_rnd = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
